// File: rtl/rupt_request_latch_pkg.sv
// rupt_request_latch_pkg: rupt source indices, source count and vector layout
package rupt_request_latch_pkg;
  localparam int NSRC = 10;
  localparam int AD_W = 4;
  localparam int RS_T6 = 0;
  localparam int RS_T5 = 1;
  localparam int RS_T3 = 2;
  localparam int RS_T4 = 3;
  localparam int RS_KEY1 = 4;
  localparam int RS_KEY2 = 5;
  localparam int RS_UP = 6;
  localparam int RS_DOWN = 7;
  localparam int RS_RADAR = 8;
  localparam int RS_HAND = 9;
  localparam logic [11:0] VEC_BASE = 12'o4000;
  localparam logic [11:0] VEC_STRIDE = 12'd4;
  function automatic logic [11:0] rupt_vector(input logic [AD_W-1:0] ad);
    return VEC_BASE + VEC_STRIDE * (12'(ad) + 12'd1);
  endfunction
endpackage

// File: rtl/rupt_edge_sync.sv
// rupt_edge_sync: two-flop synchroniser with rising-edge pulse per bit
module rupt_edge_sync #(
  parameter int W = 1
) (
  input  logic         CLOCK,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, s2, prev;
  logic [2:0] vld;
  always_ff @(posedge CLOCK)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      vld <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      prev <= s2;
      vld <= {vld[1:0], 1'b1};
    end
  // levels already high when reset lifts must not look like fresh edges
  assign rise = vld[2] ? s2 & ~prev : '0;
endmodule

// File: rtl/rupt_request_latch.sv
// rupt_request_latch: latches rupt source edges, presents the winner to rupt service, times rupt lock
module rupt_request_latch #(
  parameter int NSRC = rupt_request_latch_pkg::NSRC,
  parameter int LOCK_TICKS = 140,
  parameter int LOCK_W = 8
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic [NSRC-1:0] RSRC,
  input  logic            GOJAM,
  input  logic            INHINT,
  input  logic            RRPA,
  input  logic            RESUME,
  input  logic            TICK,
  output logic            RUPTREQ,
  output logic [3:0]      RPTAD,
  output logic [NSRC-1:0] PEND,
  output logic            IIP,
  output logic            RLOCK
);
  import rupt_request_latch_pkg::*;
  logic [NSRC-1:0] rise, clr;
  logic [AD_W-1:0] win;
  logic [LOCK_W-1:0] cnt;
  logic ack;
  rupt_edge_sync #(.W(NSRC)) u_sync (
    .CLOCK(CLOCK),
    .rst(rst & ~GOJAM),
    .d(RSRC),
    .rise(rise)
  );
  assign ack = RRPA & RUPTREQ;
  assign clr = ack ? NSRC'(1) << RPTAD : '0;
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (PEND[i]) win = AD_W'(i);
  end
  // a fresh edge on the source being acknowledged re-pends it
  always_ff @(posedge CLOCK)
    if (!rst || GOJAM) begin
      PEND <= '0;
      IIP <= 1'b0;
      cnt <= '0;
      RUPTREQ <= 1'b0;
      RPTAD <= '0;
      RLOCK <= 1'b0;
    end else begin
      PEND <= (PEND & ~clr) | rise;
      RUPTREQ <= !ack && |PEND && !INHINT && !IIP;
      RPTAD <= win;
      IIP <= ack || (IIP && !RESUME);
      cnt <= !IIP ? '0 : (TICK && cnt != LOCK_W'(LOCK_TICKS)) ? cnt + 1'b1 : cnt;
      RLOCK <= IIP && TICK && cnt == LOCK_W'(LOCK_TICKS - 1);
    end
endmodule

// File: tb/tb_rupt_request_latch.sv
// tb_rupt_request_latch: directed and randomized checks against a behavioural rupt model
module tb_rupt_request_latch;
  import rupt_request_latch_pkg::*;
  localparam int LT = 5;
  logic CLOCK = 0, rst = 0, GOJAM = 0, INHINT = 0, RRPA = 0, RESUME = 0, TICK = 0;
  logic [NSRC-1:0] RSRC = '0;
  logic RUPTREQ, IIP, RLOCK;
  logic [3:0] RPTAD;
  logic [NSRC-1:0] PEND;
  int ntests = 0, nfail = 0;
  logic [NSRC-1:0] h1 = '0, h2 = '0, h3 = '0, m_pend = '0;
  int m_run = 0, m_ticks = 0, m_ad = 0;
  logic m_req = 0, m_iip = 0, m_lock = 0;
  logic [16:0] dut_v, mod_v;

  rupt_request_latch #(.LOCK_TICKS(LT)) dut (
    .CLOCK(CLOCK), .rst(rst), .RSRC(RSRC), .GOJAM(GOJAM), .INHINT(INHINT),
    .RRPA(RRPA), .RESUME(RESUME), .TICK(TICK), .RUPTREQ(RUPTREQ),
    .RPTAD(RPTAD), .PEND(PEND), .IIP(IIP), .RLOCK(RLOCK)
  );

  always #5 CLOCK = ~CLOCK;
  assign dut_v = {RUPTREQ, RPTAD, PEND, IIP, RLOCK};
  assign mod_v = {m_req, 4'(m_ad), m_pend, m_iip, m_lock};

  // reference: a source edge counts once four clean clocks of history exist; lock = LT-th tick of a service
  initial forever begin
    logic [NSRC-1:0] rise;
    logic ack;
    int lowest;
    @(posedge CLOCK);
    if (!rst || GOJAM) begin
      h1 = '0; h2 = '0; h3 = '0; m_pend = '0;
      m_run = 0; m_ticks = 0; m_ad = 0; m_req = 0; m_iip = 0; m_lock = 0;
    end else begin
      m_run = (m_run < 4) ? m_run + 1 : 4;
      rise = (m_run >= 4) ? h2 & ~h3 : '0;
      h3 = h2; h2 = h1; h1 = RSRC;
      ack = RRPA && m_req;
      lowest = 0;
      for (int i = 0; i < NSRC; i++) if (m_pend[i]) begin lowest = i; break; end
      m_lock = m_iip && TICK && (m_ticks + 1 == LT);
      m_ticks = m_iip ? m_ticks + int'(TICK) : 0;
      m_req = !ack && m_pend != 0 && !INHINT && !m_iip;
      if (ack) m_pend[m_ad] = 1'b0;
      m_pend = m_pend | rise;
      m_ad = lowest;
      m_iip = ack || (m_iip && !RESUME);
    end
  end

  task automatic test_reset();
    rst = 0; RSRC = '1;
    repeat (2) @(negedge CLOCK);
    ntests++; if (dut_v !== 17'h0) begin nfail++; $display("FAIL reset_outputs got %h exp %h", dut_v, 17'h0); end
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK);
      ntests++; if (PEND !== '0 || dut_v !== mod_v) begin nfail++; $display("FAIL reset_held_high cyc %0d got %h exp %h", i, dut_v, mod_v); end
    end
    RSRC = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL reset_release cyc %0d got %h exp %h", i, dut_v, mod_v); end
    end
  endtask

  task automatic test_single();
    RSRC[RS_KEY1] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLOCK);
      ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL single_model cyc %0d got %h exp %h", i, dut_v, mod_v); end
      if (i == 3) begin ntests++; if (PEND !== 10'h010) begin nfail++; $display("FAIL single_pend got %h exp %h", PEND, 10'h010); end end
    end
    ntests++; if ({RUPTREQ, RPTAD} !== 5'h14) begin nfail++; $display("FAIL single_req got %h exp %h", {RUPTREQ, RPTAD}, 5'h14); end
    ntests++; if (rupt_vector(RPTAD) !== 12'o4024) begin nfail++; $display("FAIL single_vector got %o exp %o", rupt_vector(RPTAD), 12'o4024); end
    RRPA = 1;
    @(negedge CLOCK); RRPA = 0;
    ntests++; if ({RUPTREQ, PEND, IIP} !== {1'b0, 10'h0, 1'b1}) begin nfail++; $display("FAIL single_ack got %h exp %h", {RUPTREQ, PEND, IIP}, {1'b0, 10'h0, 1'b1}); end
    RSRC = '0; RESUME = 1;
    @(negedge CLOCK); RESUME = 0;
    ntests++; if (IIP !== 1'b0 || dut_v !== mod_v) begin nfail++; $display("FAIL single_resume got %h exp %h", dut_v, mod_v); end
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic test_priority();
    RSRC[RS_RADAR] = 1'b1; RSRC[RS_T5] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL prio_model cyc %0d got %h exp %h", i, dut_v, mod_v); end
    end
    ntests++; if ({RUPTREQ, RPTAD} !== 5'h11) begin nfail++; $display("FAIL prio_first got %h exp %h", {RUPTREQ, RPTAD}, 5'h11); end
    RRPA = 1;
    @(negedge CLOCK); RRPA = 0;
    ntests++; if ({RUPTREQ, PEND, IIP} !== {1'b0, 10'h100, 1'b1}) begin nfail++; $display("FAIL prio_ack got %h exp %h", {RUPTREQ, PEND, IIP}, {1'b0, 10'h100, 1'b1}); end
    @(negedge CLOCK);
    ntests++; if ({RUPTREQ, RPTAD} !== 5'h08) begin nfail++; $display("FAIL prio_next got %h exp %h", {RUPTREQ, RPTAD}, 5'h08); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      ntests++; if (RUPTREQ !== 1'b0 || dut_v !== mod_v) begin nfail++; $display("FAIL prio_held cyc %0d got %h exp %h", i, dut_v, mod_v); end
    end
    RESUME = 1;
    @(negedge CLOCK); RESUME = 0;
    ntests++; if ({RUPTREQ, IIP} !== 2'b00) begin nfail++; $display("FAIL prio_resume got %b exp %b", {RUPTREQ, IIP}, 2'b00); end
    @(negedge CLOCK);
    ntests++; if ({RUPTREQ, RPTAD} !== 5'h18) begin nfail++; $display("FAIL prio_second got %h exp %h", {RUPTREQ, RPTAD}, 5'h18); end
    GOJAM = 1; RSRC = '0;
    @(negedge CLOCK); GOJAM = 0;
    repeat (5) @(negedge CLOCK);
  endtask

  task automatic test_inhint_collision();
    INHINT = 1; RSRC[RS_UP] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL inhint_model cyc %0d got %h exp %h", i, dut_v, mod_v); end
    end
    ntests++; if ({PEND[RS_UP], RUPTREQ} !== 2'b10) begin nfail++; $display("FAIL inhint_mask got %b exp %b", {PEND[RS_UP], RUPTREQ}, 2'b10); end
    RSRC[RS_UP] = 1'b0; INHINT = 0;
    @(negedge CLOCK);
    ntests++; if ({RUPTREQ, RPTAD} !== 5'h16) begin nfail++; $display("FAIL inhint_release got %h exp %h", {RUPTREQ, RPTAD}, 5'h16); end
    repeat (2) @(negedge CLOCK);
    RSRC[RS_UP] = 1'b1;
    repeat (2) @(negedge CLOCK);
    RRPA = 1;
    @(negedge CLOCK); RRPA = 0;
    ntests++; if ({PEND[RS_UP], IIP, RUPTREQ} !== 3'b110 || dut_v !== mod_v) begin nfail++; $display("FAIL collision got %h exp %h", dut_v, mod_v); end
    GOJAM = 1; RSRC = '0;
    @(negedge CLOCK); GOJAM = 0;
    repeat (5) @(negedge CLOCK);
  endtask

  task automatic test_rupt_lock();
    for (int s = 0; s < 2; s++) begin
      RSRC = '0;
      RSRC[s == 0 ? RS_T3 : RS_T4] = 1'b1;
      repeat (4) @(negedge CLOCK);
      RRPA = 1;
      @(negedge CLOCK); RRPA = 0;
      ntests++; if (IIP !== 1'b1) begin nfail++; $display("FAIL lock_iip svc %0d got %b exp 1", s, IIP); end
      for (int k = 0; k < LT + (s == 0 ? 3 : 0); k++) begin
        TICK = 1;
        @(negedge CLOCK); TICK = 0;
        ntests++; if (RLOCK !== (k == LT - 1) || dut_v !== mod_v) begin nfail++; $display("FAIL lock_tick svc %0d tick %0d rlock %b exp %b got %h exp %h", s, k, RLOCK, k == LT - 1, dut_v, mod_v); end
        @(negedge CLOCK);
        ntests++; if (RLOCK !== 1'b0) begin nfail++; $display("FAIL lock_gap svc %0d tick %0d got %b exp 0", s, k, RLOCK); end
      end
      RESUME = 1;
      @(negedge CLOCK); RESUME = 0;
      repeat (3) @(negedge CLOCK);
    end
    GOJAM = 1; RSRC = '0;
    @(negedge CLOCK); GOJAM = 0;
    repeat (5) @(negedge CLOCK);
  endtask

  task automatic test_gojam();
    RSRC[RS_KEY2] = 1'b1;
    repeat (4) @(negedge CLOCK);
    RRPA = 1;
    @(negedge CLOCK); RRPA = 0;
    RSRC = RSRC | 10'h203;
    for (int k = 0; k < 3; k++) begin
      TICK = 1;
      @(negedge CLOCK); TICK = 0;
      @(negedge CLOCK);
      ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL gojam_setup tick %0d got %h exp %h", k, dut_v, mod_v); end
    end
    ntests++; if ({PEND, IIP, RUPTREQ} !== {10'h203, 2'b10}) begin nfail++; $display("FAIL gojam_pre got %h exp %h", {PEND, IIP, RUPTREQ}, {10'h203, 2'b10}); end
    GOJAM = 1;
    @(negedge CLOCK); GOJAM = 0;
    ntests++; if (dut_v !== 17'h0) begin nfail++; $display("FAIL gojam_clear got %h exp %h", dut_v, 17'h0); end
    RSRC = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL gojam_after cyc %0d got %h exp %h", i, dut_v, mod_v); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK);
      ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL random cyc %0d got %h exp %h", i, dut_v, mod_v); end
      RSRC = RSRC ^ (($urandom_range(0, 5) == 0) ? NSRC'($urandom) & NSRC'($urandom) : '0);
      INHINT = ($urandom_range(0, 9) == 0) ? ~INHINT : INHINT;
      RRPA = $urandom_range(0, 3) == 0;
      RESUME = $urandom_range(0, 15) == 0;
      TICK = $urandom_range(0, 2) == 0;
      GOJAM = $urandom_range(0, 149) == 0;
      rst = $urandom_range(0, 199) != 0;
    end
    {RRPA, RESUME, TICK, GOJAM, INHINT} = '0;
    rst = 1;
    @(negedge CLOCK);
    ntests++; if (dut_v !== mod_v) begin nfail++; $display("FAIL random_end got %h exp %h", dut_v, mod_v); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_inhint_collision();
    test_rupt_lock();
    test_gojam();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
